vga_fade_core: RTL



---
 rtl/vga_fade_core.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_fade_core.sv
// vga_fade_core: full-screen fade/flash stage that blends the pixel stream toward a colour by level 0..16.
// Define FADE_FLASH_EN to enable the flash command (cmd 3) and the hold register.
module vga_fade_core #(
    parameter int CD = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          cs,
    input  logic          write,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);
    localparam int CW = CD / 3;
    localparam int AW = CW + 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT  = 2'd1,
        HOLD = 2'd2,
        IN   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    level_q, level_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic          flash_q, flash_d;
    logic [7:0]    hold_q;
    logic          bypass_q;
    logic [7:0]    step_q;
    logic [CD-1:0] color_q;
    logic          xy0_q;
    logic [CD-1:0] so_q;

    logic          xy0, tick;
    logic          wr_en, cmd_wr, cmd_out, cmd_in, cmd_flash, cmd_take;
    logic [7:0]    step_m1, hold_m1;
    logic [4:0]    level_up, level_dn;
    logic          busy;
    logic [CD-1:0] blend_rgb;

    // o = (s*(16-L) + c*L) >> 4; L=0 and L=16 reproduce s and c exactly
    function automatic logic [CW-1:0] blend_ch(input logic [CW-1:0] s,
                                               input logic [CW-1:0] c,
                                               input logic [4:0]    lvl);
        logic [AW-1:0] acc;
        acc = AW'(s) * (AW'(5'd16) - AW'(lvl)) + AW'(c) * AW'(lvl);
        return CW'(acc >> 4);
    endfunction

    assign xy0  = (x == 11'd0) && (y == 11'd0);
    assign tick = xy0 && !xy0_q;

    assign wr_en    = cs && write;
    assign cmd_wr   = wr_en && (addr[2:0] == 3'd1);
    assign cmd_out  = cmd_wr && (wr_data[1:0] == 2'd1);
    assign cmd_in   = cmd_wr && (wr_data[1:0] == 2'd2);
    assign cmd_take = (cmd_out && (state_q == IDLE || state_q == IN))
                   || (cmd_in && (state_q == OUT || state_q == HOLD))
                   || (cmd_flash && state_q == IDLE);

    assign step_m1  = (step_q == 8'd0) ? 8'd0 : step_q - 8'd1;
    assign hold_m1  = hold_q - 8'd1;
    assign level_up = (level_q >= 5'd16) ? 5'd16 : level_q + 5'd1;
    assign level_dn = (level_q == 5'd0) ? 5'd0 : level_q - 5'd1;
    assign busy     = (state_q != IDLE) && !(state_q == HOLD && !flash_q);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        fcnt_d  = fcnt_q;
        flash_d = flash_q;
        if (cmd_out || cmd_in) begin
            flash_d = 1'b0;
        end
        // An effective command swallows a coincident tick
        if (cmd_take) begin
            fcnt_d  = '0;
            state_d = cmd_in ? IN : OUT;
            if (cmd_flash) begin
                flash_d = 1'b1;
            end
        end else if (tick) begin
            case (state_q)
                OUT: begin
                    if (fcnt_q == step_m1) begin
                        fcnt_d  = '0;
                        level_d = level_up;
                        if (level_up == 5'd16) begin
                            state_d = (flash_d && hold_q == 8'd0) ? IN : HOLD;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end
                HOLD: begin
                    // fcnt doubles as the hold-frame counter while flashing
                    if (flash_d) begin
                        if (hold_q == 8'd0 || fcnt_q == hold_m1) begin
                            state_d = IN;
                            fcnt_d  = '0;
                        end else begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                end
                IN: begin
                    if (fcnt_q == step_m1) begin
                        fcnt_d  = '0;
                        level_d = level_dn;
                        if (level_dn == 5'd0) begin
                            state_d = IDLE;
                            flash_d = 1'b0;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= '0;
            fcnt_q  <= '0;
            xy0_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            fcnt_q  <= fcnt_d;
            xy0_q   <= xy0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bypass_q <= 1'b0;
            step_q   <= 8'd1;
            color_q  <= '0;
        end else if (wr_en) begin
            case (addr[2:0])
                3'd0:    bypass_q <= wr_data[0];
                3'd2:    step_q   <= wr_data[7:0];
                3'd3:    color_q  <= wr_data[CD-1:0];
                default: ;
            endcase
        end
    end

`ifdef FADE_FLASH_EN
    assign cmd_flash = cmd_wr && (wr_data[1:0] == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_q <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            flash_q <= flash_d;
            if (wr_en && addr[2:0] == 3'd4) begin
                hold_q <= wr_data[7:0];
            end
        end
    end
`else
    logic unused_flash;

    assign cmd_flash    = 1'b0;
    assign flash_q      = 1'b0;
    assign hold_q       = 8'd0;
    assign unused_flash = flash_d;
`endif

    always_comb begin
        blend_rgb = '0;
        for (int i = 0; i < 3; i++) begin
            blend_rgb[i*CW +: CW] = blend_ch(si_rgb[i*CW +: CW], color_q[i*CW +: CW], level_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            so_q <= '0;
        end else begin
            so_q <= bypass_q ? si_rgb : blend_rgb;
        end
    end

    assign so_rgb = so_q;

    always_comb begin
        rd_data = 32'd0;
        case (addr[2:0])
            3'd0:    rd_data = {23'd0, busy, state_q, level_q, bypass_q};
            3'd2:    rd_data = {24'd0, step_q};
            3'd3:    rd_data = {{(32-CD){1'b0}}, color_q};
            3'd4:    rd_data = {24'd0, hold_q};
            default: rd_data = 32'd0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{addr[13:3], wr_data[31:CD]};

endmodule
